gbdt_dma_feeder: RTL and testbench

- Upstream stage of the GBDT accelerator.
- Accepts a 32-bit word stream from the system DMA engine and packs it into DMA_RATE-wide beats in a small FIFO.
- Drives DMA_data/DMA_valid into the accelerator core: exactly cfg_beats beats per sample frame, then holds off until the accelerator reports done.
- Required because the DMA_valid interface has no backpressure; the feeder absorbs source jitter and enforces frame boundaries.

---
 rtl/gbdt_dma_feeder_if.sv | 29 ++
 rtl/gbdt_dma_feeder.sv | 228 ++++++++++++++++++++++
 tb/tb_gbdt_dma_feeder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gbdt_dma_feeder_if.sv
// Bus bundle between the system DMA word source, the feeder and the
// accelerator core: 32-bit source word handshake plus the packed beat output.
// master = the side that drives source words and observes beats,
// slave  = the feeder itself.
interface gbdt_dma_feeder_if #(
    parameter int DMA_RATE = 64
) ();
    logic [31:0]         src_data;
    logic                src_valid;
    logic                src_ready;
    logic [DMA_RATE-1:0] DMA_data;
    logic                DMA_valid;

    modport master (
        output src_data,
        output src_valid,
        input  src_ready,
        input  DMA_data,
        input  DMA_valid
    );

    modport slave (
        input  src_data,
        input  src_valid,
        output src_ready,
        output DMA_data,
        output DMA_valid
    );
endinterface

// File: rtl/gbdt_dma_feeder.sv
// gbdt_dma_feeder: packs a 32-bit DMA word stream into DMA_RATE-wide beats,
// buffers them in a small FIFO and emits exactly cfg_beats beats per frame to
// the accelerator core, then waits for gbdt_done before accepting a new frame.
// The accelerator side has no backpressure, so the FIFO absorbs source jitter.
// Optional feature macro: GBDT_FEED_UNDERRUN_CNT_EN (saturating count of
// SEND cycles spent with the FIFO empty).
module gbdt_dma_feeder #(
    parameter int DMA_RATE   = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int BEATS_W    = 8
) (
    input  logic               gbdt_clk,
    input  logic               gbdt_rst,
    input  logic [BEATS_W-1:0] cfg_beats,
    input  logic               feed_start,
    gbdt_dma_feeder_if.slave   bus,
    input  logic               gbdt_done,
    output logic               feed_busy,
    output logic               frame_sent,
    output logic [15:0]        underrun_cnt
);

    localparam int WPB   = DMA_RATE / 32;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WPB - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [BEATS_W-1:0] REM_ONE  = BEATS_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;

    logic [IDX_W-1:0]    idx_r;
    logic [DMA_RATE-1:0] pack_r;
    logic [DMA_RATE-1:0] beat_s;

    logic [DMA_RATE-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                src_ready_s;
    logic                word_hs_s;
    logic                push_s;
    logic                pop_s;
    logic                start_acc_s;
    logic                done_s;

    logic [BEATS_W-1:0]  remaining_r;
    logic [DMA_RATE-1:0] dma_data_r;
    logic                dma_valid_r;
    logic                frame_sent_r;

    // Full/empty come from the registered count only: a pop in the same cycle
    // does not free a slot for the incoming last word.
    assign fifo_full_s  = (count_r == DEPTH_C);
    assign fifo_empty_s = (count_r == '0);
    assign src_ready_s  = !gbdt_rst && ((idx_r != LAST_IDX) || !fifo_full_s);
    assign word_hs_s    = bus.src_valid && src_ready_s;
    assign push_s       = word_hs_s && (idx_r == LAST_IDX);

    // Current beat image with the incoming word merged into its lane.
    always_comb begin
        beat_s = pack_r;
        beat_s[32*int'(idx_r) +: 32] = bus.src_data;
    end

    // Packer: collects words into lanes, word 0 in the least significant lane.
    always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
        if (gbdt_rst) begin
            idx_r  <= '0;
            pack_r <= '0;
        end else if (word_hs_s) begin
            pack_r <= beat_s;
            if (idx_r == LAST_IDX) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_ONE;
            end
        end
    end

    // Beat storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge gbdt_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= beat_s;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
        if (gbdt_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame state register.
    always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
        if (gbdt_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-cycle control: start acceptance, pops, frame end.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        start_acc_s  = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (feed_start && (cfg_beats != '0)) begin
                    start_acc_s  = 1'b1;
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (remaining_r == REM_ONE) begin
                        next_state_s = ST_WAIT;
                    end else begin
                        next_state_s = ST_SEND;
                    end
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (gbdt_done) begin
                    done_s       = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Beat counter for the current frame, loaded only by an accepted start.
    always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
        if (gbdt_rst) begin
            remaining_r <= '0;
        end else if (start_acc_s) begin
            remaining_r <= cfg_beats;
        end else if (pop_s) begin
            remaining_r <= remaining_r - REM_ONE;
        end
    end

    // Registered accelerator outputs; data holds between beats.
    always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
        if (gbdt_rst) begin
            dma_data_r   <= '0;
            dma_valid_r  <= 1'b0;
            frame_sent_r <= 1'b0;
        end else begin
            dma_valid_r  <= pop_s;
            frame_sent_r <= done_s;
            if (pop_s) begin
                dma_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

`ifdef GBDT_FEED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_r;
    logic        underrun_s;

    assign underrun_s = (state_r == ST_SEND) && fifo_empty_s;

    // Saturating count of starved SEND cycles, cleared by each accepted start.
    always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
        if (gbdt_rst) begin
            underrun_cnt_r <= 16'h0000;
        end else if (start_acc_s) begin
            underrun_cnt_r <= 16'h0000;
        end else if (underrun_s && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'h0001;
        end
    end

    assign underrun_cnt = underrun_cnt_r;
`else
    assign underrun_cnt = 16'h0000;
`endif

    assign bus.src_ready = src_ready_s;
    assign bus.DMA_data  = dma_data_r;
    assign bus.DMA_valid = dma_valid_r;
    assign feed_busy     = (state_r != ST_IDLE);
    assign frame_sent    = frame_sent_r;

endmodule

// File: tb/tb_gbdt_dma_feeder.sv
// Directed bench for gbdt_dma_feeder (DMA_RATE=64, FIFO_DEPTH=4).
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_gbdt_dma_feeder;

    logic        gbdt_clk = 1'b0;
    logic        gbdt_rst = 1'b1;
    logic [7:0]  cfg_beats = 8'd0;
    logic        feed_start = 1'b0;
    logic        gbdt_done = 1'b0;
    logic        feed_busy;
    logic        frame_sent;
    logic [15:0] underrun_cnt;

    gbdt_dma_feeder_if #(.DMA_RATE(64)) bus ();

    gbdt_dma_feeder #(
        .DMA_RATE  (64),
        .FIFO_DEPTH(4),
        .BEATS_W   (8)
    ) dut (
        .gbdt_clk    (gbdt_clk),
        .gbdt_rst    (gbdt_rst),
        .cfg_beats   (cfg_beats),
        .feed_start  (feed_start),
        .bus         (bus),
        .gbdt_done   (gbdt_done),
        .feed_busy   (feed_busy),
        .frame_sent  (frame_sent),
        .underrun_cnt(underrun_cnt)
    );

    always #5 gbdt_clk = ~gbdt_clk;

    int          cyc = 0;
    int          total_checks = 0;
    int          passed_checks = 0;
    logic [63:0] beat_q[$];
    int          beat_cyc_q[$];

    // Cycle counter used to time-stamp beats.
    always @(posedge gbdt_clk) cyc <= cyc + 1;

    // Beat recorder.
    always @(negedge gbdt_clk) begin
        if (!gbdt_rst && bus.DMA_valid) begin
            beat_q.push_back(bus.DMA_data);
            beat_cyc_q.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic tick;
        @(posedge gbdt_clk);
        #1;
    endtask

    task automatic clear_beats;
        beat_q.delete();
        beat_cyc_q.delete();
    endtask

    task automatic do_reset;
        gbdt_rst      = 1'b1;
        feed_start    = 1'b0;
        gbdt_done     = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_data  = 32'h0;
        repeat (2) tick;
        gbdt_rst = 1'b0;
        tick;
        clear_beats;
    endtask

    task automatic pulse_start(input logic [7:0] cfg);
        feed_start = 1'b1;
        cfg_beats  = cfg;
        tick;
        feed_start = 1'b0;
    endtask

    task automatic pulse_done;
        gbdt_done = 1'b1;
        tick;
        gbdt_done = 1'b0;
    endtask

    // Present one word and hold it until it is accepted (bounded).
    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        bus.src_valid = 1'b1;
        bus.src_data  = w;
        for (int i = 0; i < 50; i++) begin
            @(negedge gbdt_clk);
            if (bus.src_ready) begin
                tick;
                ok = 1'b1;
                break;
            end
            tick;
        end
        bus.src_valid = 1'b0;
        if (!ok) check_val("src_ready_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bus.src_valid = 1'b0;
        bus.src_data  = 32'h0;

        // Reset state
        #2;
        check_val("rst_src_ready", {63'd0, bus.src_ready}, 64'd0);
        check_val("rst_dma_valid", {63'd0, bus.DMA_valid}, 64'd0);
        check_val("rst_dma_data", bus.DMA_data, 64'd0);
        check_val("rst_feed_busy", {63'd0, feed_busy}, 64'd0);
        check_val("rst_frame_sent", {63'd0, frame_sent}, 64'd0);
        check_val("rst_underrun", {48'd0, underrun_cnt}, 64'd0);
        repeat (2) tick;
        gbdt_rst = 1'b0;
        tick;
        clear_beats;

        // Basic frame of three beats
        pulse_start(8'd3);
        for (int i = 1; i <= 6; i++) send_word(i);
        repeat (5) tick;
        @(negedge gbdt_clk);
        check_val("t1_beats", beat_q.size(), 64'd3);
        check_val("t1_beat0", beat_q[0], 64'h00000002_00000001);
        check_val("t1_beat1", beat_q[1], 64'h00000004_00000003);
        check_val("t1_beat2", beat_q[2], 64'h00000006_00000005);
        check_val("t1_busy_wait", {63'd0, feed_busy}, 64'd1);
        check_val("t1_no_early_sent", {63'd0, frame_sent}, 64'd0);
        check_val("t1_data_hold", bus.DMA_data, 64'h00000006_00000005);
        tick;
        pulse_done;
        @(negedge gbdt_clk);
        check_val("t1_frame_sent", {63'd0, frame_sent}, 64'd1);
        check_val("t1_idle", {63'd0, feed_busy}, 64'd0);
        tick;
        @(negedge gbdt_clk);
        check_val("t1_sent_pulse", {63'd0, frame_sent}, 64'd0);

        // Prefetch while IDLE, then four back-to-back beats
        do_reset;
        for (int i = 1; i <= 9; i++) send_word(i);
        @(negedge gbdt_clk);
        check_val("t2_ready_full", {63'd0, bus.src_ready}, 64'd0);
        tick;
        feed_start    = 1'b1;
        cfg_beats     = 8'd4;
        bus.src_valid = 1'b1;
        bus.src_data  = 32'd10;
        tick;
        feed_start = 1'b0;
        @(negedge gbdt_clk);
        check_val("t2_ready_before_pop", {63'd0, bus.src_ready}, 64'd0);
        check_val("t2_valid_latency", {63'd0, bus.DMA_valid}, 64'd0);
        tick;
        @(negedge gbdt_clk);
        check_val("t2_ready_after_pop", {63'd0, bus.src_ready}, 64'd1);
        check_val("t2_first_valid", {63'd0, bus.DMA_valid}, 64'd1);
        tick;
        bus.src_valid = 1'b0;
        repeat (5) tick;
        @(negedge gbdt_clk);
        check_val("t2_beats", beat_q.size(), 64'd4);
        check_val("t2_beat0", beat_q[0], 64'h00000002_00000001);
        check_val("t2_beat3", beat_q[3], 64'h00000008_00000007);
        check_val("t2_back_to_back", beat_cyc_q[3] - beat_cyc_q[0], 64'd3);
        check_val("t2_busy_wait", {63'd0, feed_busy}, 64'd1);
        tick;
        pulse_done;

        // Underrun gap
        do_reset;
        pulse_start(8'd2);
        send_word(32'h11);
        send_word(32'h12);
        repeat (5) tick;
        send_word(32'h13);
        send_word(32'h14);
        repeat (5) tick;
        @(negedge gbdt_clk);
        check_val("t3_beats", beat_q.size(), 64'd2);
        check_val("t3_beat0", beat_q[0], 64'h00000012_00000011);
        check_val("t3_beat1", beat_q[1], 64'h00000014_00000013);
        check_val("t3_gap", {63'd0, (beat_cyc_q[1] - beat_cyc_q[0]) >= 6}, 64'd1);
`ifdef GBDT_FEED_UNDERRUN_CNT_EN
        check_val("t3_underrun_ge5", {63'd0, underrun_cnt >= 16'd5}, 64'd1);
`else
        check_val("t3_underrun_off", {48'd0, underrun_cnt}, 64'd0);
`endif

        // Ignored starts
        do_reset;
        pulse_start(8'd0);
        @(negedge gbdt_clk);
        check_val("t4_zero_start", {63'd0, feed_busy}, 64'd0);
        tick;
        pulse_start(8'd2);
        @(negedge gbdt_clk);
        check_val("t4_started", {63'd0, feed_busy}, 64'd1);
        tick;
        pulse_start(8'd5);
        for (int i = 0; i < 6; i++) send_word(32'h20 + i);
        repeat (6) tick;
        @(negedge gbdt_clk);
        check_val("t4_beats", beat_q.size(), 64'd2);
        check_val("t4_beat1", beat_q[1], 64'h00000023_00000022);
        check_val("t4_busy_wait", {63'd0, feed_busy}, 64'd1);

        // Asynchronous reset mid-frame
        do_reset;
        for (int i = 0; i < 8; i++) send_word(32'h40 + i);
        pulse_start(8'd4);
        tick;
        @(negedge gbdt_clk);
        check_val("t5_first_beat", {63'd0, bus.DMA_valid}, 64'd1);
        #2;
        gbdt_rst = 1'b1;
        #1;
        check_val("t5_rst_valid", {63'd0, bus.DMA_valid}, 64'd0);
        check_val("t5_rst_data", bus.DMA_data, 64'd0);
        check_val("t5_rst_busy", {63'd0, feed_busy}, 64'd0);
        check_val("t5_rst_ready", {63'd0, bus.src_ready}, 64'd0);
        repeat (2) tick;
        gbdt_rst = 1'b0;
        @(negedge gbdt_clk);
        check_val("t5_ready_release", {63'd0, bus.src_ready}, 64'd1);
        tick;
        clear_beats;
        pulse_start(8'd1);
        send_word(32'hA1);
        send_word(32'hA2);
        repeat (5) tick;
        @(negedge gbdt_clk);
        check_val("t5_beats", beat_q.size(), 64'd1);
        check_val("t5_beat0", beat_q[0], 64'h000000A2_000000A1);
        tick;
        pulse_done;

        // Long stall in SEND, then counter clear on the next start
        do_reset;
        pulse_start(8'd1);
`ifdef GBDT_FEED_UNDERRUN_CNT_EN
        repeat (70000) tick;
        @(negedge gbdt_clk);
        check_val("t6_saturated", {48'd0, underrun_cnt}, 64'h0000_0000_0000_FFFF);
`else
        repeat (20) tick;
        @(negedge gbdt_clk);
        check_val("t6_counter_off", {48'd0, underrun_cnt}, 64'd0);
`endif
        tick;
        send_word(32'h1);
        send_word(32'h2);
        repeat (3) tick;
        pulse_done;
        pulse_start(8'd1);
        @(negedge gbdt_clk);
        check_val("t6_cleared", {48'd0, underrun_cnt}, 64'd0);
        check_val("t6_busy", {63'd0, feed_busy}, 64'd1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
